data_mem: RTL and testbench
===========================

# data_mem

Data memory for the single-cycle datapath. Sits directly upstream of the writeback select stage: its load result drives that stage's `ans1` input, while the ALU result drives `ans`. Provides byte-, halfword- and word-granular loads and stores with sign/zero extension, and flags misaligned or illegal accesses. Storage is written synchronously; reads are combinational, so a load completes within the same cycle.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, ≥ 4.
- `AW`, $clog2(DEPTH): word-index width.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `r_en`  in  1  load request; same signal that selects `ans1` in writeback.
- `w_en`  in  1  store request.
- `addr`  in  32  byte address from the ALU.
- `wdata`  in  32  store data (rs2); low byte/half used for SB/SH.
- `funct3`  in  3  access size/sign.
- `rdata`  out  32  load result; drives writeback `ans1`.
- `access_err`  out  1  misaligned or illegal access this cycle.

## Operation
- Word index = `addr[AW+1:2]`; upper address bits ignored, so the address wraps modulo DEPTH*4 bytes.
- Byte offset = `addr[1:0]`. Little-endian: byte 0 is `[7:0]`.
- Load encodings: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. LB/LH sign-extend; LBU/LHU zero-extend.
- Store encodings: 000 SB, 001 SH, 010 SW. Only the addressed byte lanes change.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: any value other than 000/001/010.
- Misaligned: halfword with `addr[0]=1`; word with `addr[1:0]≠0`.
- `access_err` = (`r_en` or `w_en`) and (illegal or misaligned).
- On error:
  - Store is suppressed; memory is unchanged.
  - `rdata` = 0.
- `r_en=0`: `rdata` = 0, regardless of `addr`.
- `w_en=0`: no write.
- `r_en` and `w_en` both high:
  - Legal only if funct3 is legal for both the load and the store; otherwise `access_err`=1 and nothing is written.
  - `rdata` shows pre-write contents.
- While `rst`=1:
  - `rdata`=0 and `access_err`=0.
  - The store is ignored.

## Timing
- Reset: at each rising edge with `rst`=1, every word is cleared to 0x00000000. The clear takes one cycle regardless of DEPTH.
- Outputs are combinational and show these values while `rst` is high: `rdata`=0, `access_err`=0.
- Load latency is 0 cycles: `rdata` is valid in the same cycle that `addr`, `funct3` and `r_en` are applied.
- Store: memory updates at the rising edge where `w_en`=1, `rst`=0 and no error. The new value is visible combinationally from the following cycle.
- Load and store to the same word in the same cycle: the load returns old data (read-before-write).
- Reset asserted in the same cycle as a store: reset wins and the word is cleared.
- Back-to-back stores to the same word in consecutive cycles: each applies in order, and only the last value remains.

## Structure
- Shared package `mem_pkg` holds:
  - Load constants: `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
  - Store constants: `F3_SB`, `F3_SH`, `F3_SW`.
  - Function `is_misaligned(funct3, addr[1:0])`.
- Sub-module `load_align` is combinational. It takes the raw word, offset and funct3, and produces the extended 32-bit `rdata`.
- `data_mem` holds the array and byte-lane write-enable generation.

## Test plan
- **Reset clear.** Store SW 0xDEADBEEF to addr 0x10, then hold `rst`=1 for 1 cycle. Required: LW of 0x10 returns 0x00000000; `rdata`=0 during reset.
- **Word round-trip and wrap.**
  - SW 0x12345678 to 0x20, then LW of 0x20 returns 0x12345678.
  - With DEPTH=256, LW of 0x420 returns the same value (index wrap).
- **Byte lanes and extension.** Following the word store above:
  - SB 0x000000AA to 0x21 → LW of 0x20 returns 0x1234AA78.
  - LB of 0x21 returns 0xFFFFFFAA.
  - LBU of 0x21 returns 0x000000AA.
- **Halfword.** After SH 0x00008001 to 0x22:
  - LH of 0x22 returns 0xFFFF8001.
  - LHU of 0x22 returns 0x00008001.
- **Misaligned and illegal accesses.**
  - SW to 0x21 → `access_err`=1 and memory is unchanged.
  - LH of 0x23 → `access_err`=1, `rdata`=0.
  - Load with funct3=011 → `access_err`=1.
- **Simultaneous events.**
  - `r_en`=`w_en`=1 at 0x30 with SW 0x55555555 over 0xAAAAAAAA: `rdata`=0xAAAAAAAA that cycle, 0x55555555 the next.
  - `rst`=1 together with a store: word reads 0 afterwards.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and access-classification helpers for the data memory.
// Both the top level and the load aligner import this package.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_NONE = 2'b11
  } acc_size_e;

  // funct3[1:0] encodes the access width for every legal load and store.
  function automatic acc_size_e size_of(input logic [2:0] funct3);
    acc_size_e sz;
    case (funct3[1:0])
      2'b00:   sz = SZ_BYTE;
      2'b01:   sz = SZ_HALF;
      2'b10:   sz = SZ_WORD;
      default: sz = SZ_NONE;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] offset);
    logic mis;
    case (size_of(funct3))
      SZ_HALF: mis = offset[0];
      SZ_WORD: mis = (offset != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic is_illegal_load(input logic [2:0] funct3);
    logic bad;
    case (funct3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: bad = 1'b0;
      default:                             bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic is_illegal_store(input logic [2:0] funct3);
    logic bad;
    case (funct3)
      F3_SB, F3_SH, F3_SW: bad = 1'b0;
      default:             bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte-lane enables for a store of the given width at the given offset.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3,
                                           input logic [1:0] offset);
    logic [3:0] m;
    case (size_of(funct3))
      SZ_BYTE: m = 4'b0001 << offset;
      SZ_HALF: m = offset[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: selects the addressed byte/halfword/word from
// the raw memory word and sign- or zero-extends it to 32 bits.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (offset_i)
      2'b00: byte_sel = word_i[7:0];
      2'b01: byte_sel = word_i[15:8];
      2'b10: byte_sel = word_i[23:16];
      2'b11: byte_sel = word_i[31:24];
      default: byte_sel = 8'h00;
    endcase
  end

  assign half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    rdata_o = 32'h0000_0000;
    case (funct3_i)
      F3_LB:   rdata_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   rdata_o = {{16{half_sel[15]}}, half_sel};
      F3_LW:   rdata_o = word_i;
      F3_LBU:  rdata_o = {24'h000000, byte_sel};
      F3_LHU:  rdata_o = {16'h0000, half_sel};
      default: rdata_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Word-organised data memory with byte-lane stores, combinational loads and
// access-error detection. Reset clears the whole array in a single cycle.
module data_mem
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_en,
  input  logic        w_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        access_err
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] word_idx;
  logic [1:0]    offset;
  logic          illegal;
  logic          misaligned;
  logic          err;
  logic          wr_fire;
  logic [3:0]    lane_en;
  logic [31:0]   wr_lanes;
  logic [31:0]   rd_word;
  logic [31:0]   aligned;
  logic          unused_addr_hi;

  // Upper address bits are deliberately ignored so accesses wrap.
  assign word_idx       = addr[AW+1:2];
  assign offset         = addr[1:0];
  assign unused_addr_hi = ^addr[31:AW+2];

  // With both enables high the funct3 must suit the load and the store.
  assign illegal    = (r_en && is_illegal_load(funct3)) ||
                      (w_en && is_illegal_store(funct3));
  assign misaligned = is_misaligned(funct3, offset);
  assign err        = !rst && (r_en || w_en) && (illegal || misaligned);
  assign access_err = err;

  assign wr_fire = w_en && !rst && !err;
  assign lane_en = lane_mask(funct3, offset);

  // Replicate the low byte/half across lanes so lane_en alone picks targets.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        wr_lanes[8*gi +: 8] = wdata[8*gi +: 8];
        case (size_of(funct3))
          SZ_BYTE: wr_lanes[8*gi +: 8] = wdata[7:0];
          SZ_HALF: wr_lanes[8*gi +: 8] = wdata[8*(gi%2) +: 8];
          default: wr_lanes[8*gi +: 8] = wdata[8*gi +: 8];
        endcase
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (wr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) begin
          mem_q[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
        end
      end
    end
  end

  // Read path sees the pre-edge contents, giving read-before-write.
  assign rd_word = mem_q[word_idx];

  load_align u_load_align (
    .word_i   (rd_word),
    .offset_i (offset),
    .funct3_i (funct3),
    .rdata_o  (aligned)
  );

  assign rdata = (r_en && !rst && !err) ? aligned : 32'h0000_0000;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed scenarios plus randomized
// traffic compared against a byte-array reference model.
module tb_data_mem;

  localparam int DEPTH = 256;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_en;
  logic        w_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic        access_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  ref_mem [NBYTES];
  logic [31:0] rd_s;
  logic        err_s;
  logic [31:0] exp_rd;
  logic        exp_err;

  data_mem #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .r_en       (r_en),
    .w_en       (w_en),
    .addr       (addr),
    .wdata      (wdata),
    .funct3     (funct3),
    .rdata      (rdata),
    .access_err (access_err)
  );

  always #5 clk = ~clk;

  function automatic int acc_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    if (f3[1:0] == 2'd2) return 4;
    return 0;
  endfunction

  function automatic logic model_err(input logic r, input logic w, input logic rs,
                                     input logic [2:0] f3, input logic [31:0] a);
    logic bad;
    int   n;
    if (rs || !(r || w)) return 1'b0;
    bad = 1'b0;
    if (r && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5))
      bad = 1'b1;
    if (w && f3 > 3'd2) bad = 1'b1;
    n = acc_bytes(f3);
    if (n != 0 && (a % n) != 0) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] model_load(input logic r, input logic w, input logic rs,
                                             input logic [2:0] f3, input logic [31:0] a);
    int          base;
    int          n;
    logic [31:0] v;
    if (rs || !r || model_err(r, w, rs, f3, a)) return 32'h0;
    base = int'(a % NBYTES);
    n = acc_bytes(f3);
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[base + k]) << (8 * k));
    if (f3[2] == 1'b0 && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3[2] == 1'b0 && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_commit(input logic w, input logic rs, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd);
    int base;
    if (rs) begin
      for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
    end else if (w && !model_err(r_en, w, rs, f3, a)) begin
      base = int'(a % NBYTES);
      for (int k = 0; k < acc_bytes(f3); k++) ref_mem[base + k] = wd[8*k +: 8];
    end
  endtask

  // One cycle: apply inputs, sample outputs mid-cycle, update the model at the edge.
  task automatic cycle(input logic rs, input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    rst = rs; r_en = r; w_en = w; funct3 = f3; addr = a; wdata = wd;
    exp_rd  = model_load(r, w, rs, f3, a);
    exp_err = model_err(r, w, rs, f3, a);
    #2;
    rd_s  = rdata;
    err_s = access_err;
    @(posedge clk);
    model_commit(w, rs, f3, a, wd);
    #1;
    rst = 1'b0; r_en = 1'b0; w_en = 1'b0;
  endtask

  task automatic test_reset;
    cycle(0, 0, 1, 3'd2, 32'h10, 32'hDEADBEEF);
    cycle(0, 1, 0, 3'd2, 32'h10, 32'h0);
    n_cmp++;
    if (rd_s !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL reset_pre_lw: got %h want %h", rd_s, 32'hDEADBEEF);
    end
    cycle(1, 1, 0, 3'd2, 32'h11, 32'h0);
    n_cmp++;
    if (rd_s !== 32'h0 || err_s !== 1'b0) begin
      n_bad++; $display("FAIL reset_outputs: got rdata=%h err=%b want 0/0", rd_s, err_s);
    end
    cycle(0, 1, 0, 3'd2, 32'h10, 32'h0);
    n_cmp++;
    if (rd_s !== 32'h0) begin
      n_bad++; $display("FAIL reset_clear: got %h want %h", rd_s, 32'h0);
    end
    $display("test_reset done");
  endtask

  task automatic test_word_wrap;
    cycle(0, 0, 1, 3'd2, 32'h20, 32'h12345678);
    cycle(0, 1, 0, 3'd2, 32'h20, 32'h0);
    n_cmp++;
    if (rd_s !== 32'h12345678) begin
      n_bad++; $display("FAIL word_rt: got %h want %h", rd_s, 32'h12345678);
    end
    cycle(0, 1, 0, 3'd2, 32'h420, 32'h0);
    n_cmp++;
    if (rd_s !== 32'h12345678) begin
      n_bad++; $display("FAIL word_wrap: got %h want %h", rd_s, 32'h12345678);
    end
    $display("test_word_wrap done");
  endtask

  task automatic test_byte_lanes;
    cycle(0, 0, 1, 3'd0, 32'h21, 32'h000000AA);
    cycle(0, 1, 0, 3'd2, 32'h20, 32'h0);
    n_cmp++;
    if (rd_s !== 32'h1234AA78) begin
      n_bad++; $display("FAIL sb_lane: got %h want %h", rd_s, 32'h1234AA78);
    end
    cycle(0, 1, 0, 3'd0, 32'h21, 32'h0);
    n_cmp++;
    if (rd_s !== 32'hFFFFFFAA) begin
      n_bad++; $display("FAIL lb_sext: got %h want %h", rd_s, 32'hFFFFFFAA);
    end
    cycle(0, 1, 0, 3'd4, 32'h21, 32'h0);
    n_cmp++;
    if (rd_s !== 32'h000000AA) begin
      n_bad++; $display("FAIL lbu_zext: got %h want %h", rd_s, 32'h000000AA);
    end
    $display("test_byte_lanes done");
  endtask

  task automatic test_halfword;
    cycle(0, 0, 1, 3'd1, 32'h22, 32'h00008001);
    cycle(0, 1, 0, 3'd1, 32'h22, 32'h0);
    n_cmp++;
    if (rd_s !== 32'hFFFF8001) begin
      n_bad++; $display("FAIL lh_sext: got %h want %h", rd_s, 32'hFFFF8001);
    end
    cycle(0, 1, 0, 3'd5, 32'h22, 32'h0);
    n_cmp++;
    if (rd_s !== 32'h00008001) begin
      n_bad++; $display("FAIL lhu_zext: got %h want %h", rd_s, 32'h00008001);
    end
    cycle(0, 1, 0, 3'd2, 32'h20, 32'h0);
    n_cmp++;
    if (rd_s !== 32'h8001AA78) begin
      n_bad++; $display("FAIL sh_lane: got %h want %h", rd_s, 32'h8001AA78);
    end
    $display("test_halfword done");
  endtask

  task automatic test_errors;
    cycle(0, 0, 1, 3'd2, 32'h21, 32'hFFFFFFFF);
    n_cmp++;
    if (err_s !== 1'b1) begin
      n_bad++; $display("FAIL sw_misaligned_err: got %b want 1", err_s);
    end
    cycle(0, 0, 1, 3'd4, 32'h20, 32'hFFFFFFFF);
    n_cmp++;
    if (err_s !== 1'b1) begin
      n_bad++; $display("FAIL store_illegal_err: got %b want 1", err_s);
    end
    cycle(0, 1, 0, 3'd2, 32'h20, 32'h0);
    n_cmp++;
    if (rd_s !== 32'h8001AA78) begin
      n_bad++; $display("FAIL err_no_write: got %h want %h", rd_s, 32'h8001AA78);
    end
    cycle(0, 1, 0, 3'd1, 32'h23, 32'h0);
    n_cmp++;
    if (err_s !== 1'b1 || rd_s !== 32'h0) begin
      n_bad++; $display("FAIL lh_misaligned: got err=%b rdata=%h want 1/0", err_s, rd_s);
    end
    cycle(0, 1, 0, 3'd3, 32'h20, 32'h0);
    n_cmp++;
    if (err_s !== 1'b1 || rd_s !== 32'h0) begin
      n_bad++; $display("FAIL load_f3_011: got err=%b rdata=%h want 1/0", err_s, rd_s);
    end
    cycle(0, 0, 0, 3'd3, 32'h23, 32'h0);
    n_cmp++;
    if (err_s !== 1'b0 || rd_s !== 32'h0) begin
      n_bad++; $display("FAIL idle_outputs: got err=%b rdata=%h want 0/0", err_s, rd_s);
    end
    $display("test_errors done");
  endtask

  task automatic test_simultaneous;
    cycle(0, 0, 1, 3'd2, 32'h30, 32'hAAAAAAAA);
    cycle(0, 1, 1, 3'd2, 32'h30, 32'h55555555);
    n_cmp++;
    if (rd_s !== 32'hAAAAAAAA || err_s !== 1'b0) begin
      n_bad++; $display("FAIL rbw_old: got %h err=%b want %h/0", rd_s, err_s, 32'hAAAAAAAA);
    end
    cycle(0, 1, 0, 3'd2, 32'h30, 32'h0);
    n_cmp++;
    if (rd_s !== 32'h55555555) begin
      n_bad++; $display("FAIL rbw_new: got %h want %h", rd_s, 32'h55555555);
    end
    cycle(0, 1, 1, 3'd4, 32'h30, 32'h12121212);
    n_cmp++;
    if (err_s !== 1'b1 || rd_s !== 32'h0) begin
      n_bad++; $display("FAIL rw_mixed_illegal: got err=%b rdata=%h want 1/0", err_s, rd_s);
    end
    cycle(0, 1, 0, 3'd2, 32'h30, 32'h0);
    n_cmp++;
    if (rd_s !== 32'h55555555) begin
      n_bad++; $display("FAIL rw_illegal_nowrite: got %h want %h", rd_s, 32'h55555555);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_back_to_back;
    cycle(0, 0, 1, 3'd2, 32'h50, 32'h11111111);
    cycle(0, 0, 1, 3'd2, 32'h50, 32'h22222222);
    cycle(0, 1, 0, 3'd2, 32'h50, 32'h0);
    n_cmp++;
    if (rd_s !== 32'h22222222) begin
      n_bad++; $display("FAIL back_to_back: got %h want %h", rd_s, 32'h22222222);
    end
    cycle(1, 0, 1, 3'd2, 32'h40, 32'h77777777);
    cycle(0, 1, 0, 3'd2, 32'h40, 32'h0);
    n_cmp++;
    if (rd_s !== 32'h0) begin
      n_bad++; $display("FAIL reset_beats_store: got %h want %h", rd_s, 32'h0);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_random;
    logic        rs, r, w;
    logic [2:0]  f3;
    logic [31:0] a, wd;
    int          bad_before;
    bad_before = n_bad;
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 59) == 0);
      r  = $urandom_range(0, 1) == 1;
      w  = $urandom_range(0, 2) != 0;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom & ~32'h0000_03C0;  // keep to 16 words so loads hit stores
      wd = $urandom;
      cycle(rs, r, w, f3, a, wd);
      n_cmp++;
      if (rd_s !== exp_rd || err_s !== exp_err) begin
        n_bad++;
        $display("FAIL random[%0d]: rst=%b r=%b w=%b f3=%0d addr=%h got rdata=%h err=%b want %h/%b",
                 i, rs, r, w, f3, a, rd_s, err_s, exp_rd, exp_err);
      end
    end
    $display("test_random done: %0d new mismatches", n_bad - bad_before);
  endtask

  initial begin
    rst = 1'b1; r_en = 1'b0; w_en = 1'b0; funct3 = 3'd0; addr = 32'h0; wdata = 32'h0;
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_word_wrap();
    test_byte_lanes();
    test_halfword();
    test_errors();
    test_simultaneous();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
